// File: rtl/median_window_sorter_pkg.sv
// Shared select codes and sizing helper for the running-median sorter.
// Select codes steer each sorted cell's next value during an insert/evict.
package median_pkg;

  typedef enum logic [1:0] {
    SEL_KEEP  = 2'b00,
    SEL_RIGHT = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_NEW   = 2'b11
  } sel_t;

  // Width able to hold ages 0..n-1; never narrower than one bit.
  function automatic int age_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/median_window_sorter_if.sv
// Sample-in / median-out bundle for the running-median sorter.
// No output backpressure: the master must take dout on every dout_valid pulse.
interface median_window_sorter_if
  import median_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 5,
  parameter int AW = age_width(N)
);

  logic          flush;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  din;
  logic          dout_valid;
  logic [W-1:0]  dout;
  logic [AW:0]   fill;

  modport master (
    output flush, din_valid, din,
    input  din_ready, dout_valid, dout, fill
  );

  modport slave (
    input  flush, din_valid, din,
    output din_ready, dout_valid, dout, fill
  );

endinterface

// File: rtl/median_sort_cell.sv
// One slot of the sorted window: value, age and occupancy, updated in a single cycle.
// Reports din < v and a == N-1 so the top can locate the insert and eviction points.
module median_sort_cell
  import median_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 5,
  parameter int AW = age_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  sel_t          sel,
  input  logic [W-1:0]  din,
  input  logic [W-1:0]  left_v,
  input  logic [AW-1:0] left_a,
  input  logic [W-1:0]  right_v,
  input  logic [AW-1:0] right_a,
  input  logic          ok_set,
  output logic [W-1:0]  v,
  output logic [AW-1:0] a,
  output logic          ok,
  output logic          lt,
  output logic          oldest
);

  logic [W-1:0]  v_nxt;
  logic [AW-1:0] a_nxt;
  logic          ok_nxt;

  assign lt     = din < v;
  assign oldest = a == AW'(N - 1);

  // Ages travel with their values; an empty slot keeps age 0.
  always_comb begin
    v_nxt  = v;
    a_nxt  = a;
    ok_nxt = ok;
    if (load) begin
      case (sel)
        SEL_NEW: begin
          v_nxt = din;
          a_nxt = '0;
        end
        SEL_RIGHT: begin
          v_nxt = right_v;
          a_nxt = right_a + AW'(1);
        end
        SEL_LEFT: begin
          v_nxt = left_v;
          a_nxt = left_a + AW'(1);
        end
        default: begin
          a_nxt = ok ? a + AW'(1) : a;
        end
      endcase
      ok_nxt = ok_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      a  <= '0;
      ok <= 1'b0;
    end else if (clear) begin
      v  <= '0;
      a  <= '0;
      ok <= 1'b0;
    end else begin
      v  <= v_nxt;
      a  <= a_nxt;
      ok <= ok_nxt;
    end
  end

endmodule

// File: rtl/median_window_sorter.sv
// Running median over the last N samples: one-cycle evict+insert into a sorted cell array.
// Median registered one cycle after acceptance; din_ready drops only during flush.
module median_window_sorter
  import median_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 5,
  parameter int AW = age_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  median_window_sorter_if.slave bus
);

  localparam int          MID  = (N - 1) / 2;
  localparam logic [AW:0] FULL = (AW + 1)'(N);

  logic [W-1:0]  cell_v [N];
  logic [AW-1:0] cell_a [N];
  logic [N-1:0]  cell_ok;
  logic [N-1:0]  lt_raw;
  logic [N-1:0]  old_raw;
  logic [N-1:0]  ok_set;
  sel_t          sel [N];

  logic          accept;
  logic [AW:0]   fill;
  logic [AW:0]   fill_nxt;
  logic [AW-1:0] k;
  logic [AW-1:0] k_old;
  logic [AW-1:0] p;
  logic [W-1:0]  mid_nxt;
  logic [W-1:0]  dout;
  logic          dout_valid;

  assign bus.din_ready  = ~bus.flush;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.fill       = fill;

  assign accept   = bus.din_valid & ~bus.flush;
  assign fill_nxt = (fill < FULL) ? fill + (AW + 1)'(1) : fill;

  always_comb begin
    k_old = '0;
    for (int i = 0; i < N; i++) begin
      if (cell_ok[i] && old_raw[i]) k_old = AW'(i);
    end
  end

  // While filling, the victim is the empty slot just above the valid region.
  assign k = (fill < FULL) ? fill[AW-1:0] : k_old;

  // Empty cells read as +infinity, so they never count below din.
  always_comb begin
    p = '0;
    for (int j = 0; j < N; j++) begin
      if (cell_ok[j] && !lt_raw[j] && (AW'(j) != k)) p = p + AW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sel[i] = SEL_KEEP;
      if (AW'(i) == p)
        sel[i] = SEL_NEW;
      else if ((k < p) && (k <= AW'(i)) && (AW'(i) < p))
        sel[i] = SEL_RIGHT;
      else if ((p < k) && (p < AW'(i)) && (AW'(i) <= k))
        sel[i] = SEL_LEFT;
      ok_set[i] = (AW + 1)'(i) < fill_nxt;
    end
  end

  // Neighbour indices wrap at the ends; the wrapped path is never selected.
  for (genvar g = 0; g < N; g++) begin : g_cell
    median_sort_cell #(
      .W  (W),
      .N  (N),
      .AW (AW)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (bus.flush),
      .load    (accept),
      .sel     (sel[g]),
      .din     (bus.din),
      .left_v  (cell_v[(g + N - 1) % N]),
      .left_a  (cell_a[(g + N - 1) % N]),
      .right_v (cell_v[(g + 1) % N]),
      .right_a (cell_a[(g + 1) % N]),
      .ok_set  (ok_set[g]),
      .v       (cell_v[g]),
      .a       (cell_a[g]),
      .ok      (cell_ok[g]),
      .lt      (lt_raw[g]),
      .oldest  (old_raw[g])
    );
  end

  always_comb begin
    case (sel[MID])
      SEL_NEW:   mid_nxt = bus.din;
      SEL_RIGHT: mid_nxt = cell_v[MID + 1];
      SEL_LEFT:  mid_nxt = cell_v[MID - 1];
      default:   mid_nxt = cell_v[MID];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (bus.flush) begin
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (accept) begin
        fill <= fill_nxt;
        if (fill_nxt == FULL) begin
          dout       <= mid_nxt;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_median_window_sorter.sv
// Scoreboarded bench: a sliding-window model predicts each median; a negedge monitor
// pops and compares them and checks sorted order and the age permutation every cycle.
module tb_median_window_sorter;
  import median_pkg::*;

  localparam int  W    = 8;
  localparam int  N    = 5;
  localparam time HALF = 5;

  typedef struct {
    logic [W-1:0] val;
    time          t;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  int           total = 0;
  int           bad   = 0;
  exp_t         exp_q [$];
  logic [W-1:0] win   [$];

  median_window_sorter_if #(.W(W), .N(N)) bus ();

  median_window_sorter #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] median_of(input logic [W-1:0] w [$]);
    logic [W-1:0] s [$];
    s = w;
    s.sort();
    return s[N / 2];
  endfunction

  // One clock of stimulus; the model sees exactly what the DUT accepts on that edge.
  task automatic cycle(input bit vld, input logic [W-1:0] d, input bit fl);
    bus.din_valid = vld;
    bus.din       = d;
    bus.flush     = fl;
    @(posedge clk);
    if (fl) begin
      win.delete();
    end else if (vld) begin
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) exp_q.push_back('{val: median_of(win), t: $time});
    end
    #1;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [N-1:0] mask;
    bit           err;
    exp_t         e;
    if (rst_n) begin
      if (bus.dout_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected dout=%0d with no median pending", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e.val || ($time - e.t) != HALF) begin
            bad++;
            $display("FAIL sb_dout got=%0d want=%0d latency=%0t", bus.dout, e.val, $time - e.t);
          end
        end
      end else if (exp_q.size() > 0 && ($time - exp_q[0].t) >= HALF) begin
        total++;
        bad++;
        e = exp_q.pop_front();
        $display("FAIL sb_missing dout_valid=0 want median %0d", e.val);
      end
      total++;
      err  = 1'b0;
      mask = '0;
      if (bus.fill > N) err = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (dut.cell_ok[i] !== (i < int'(bus.fill))) err = 1'b1;
        if (i + 1 < int'(bus.fill) && dut.cell_v[i] > dut.cell_v[i+1]) err = 1'b1;
        if (dut.cell_a[i] < N) mask[dut.cell_a[i]] = 1'b1;
      end
      if (bus.fill == N && mask != '1) err = 1'b1;
      if (err) begin
        bad++;
        $display("FAIL invariants fill=%0d agemask=%b ok=%b (need sorted, ok below fill, ages 0..%0d)",
                 bus.fill, mask, dut.cell_ok, N - 1);
      end
    end
  end

  task automatic test_reset();
    bus.flush = 1'b0; bus.din_valid = 1'b0; bus.din = '0;
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.fill !== 0 || bus.dout !== 0 || bus.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs fill=%0d dout=%0d dv=%b want 0 0 0", bus.fill, bus.dout, bus.dout_valid);
    end
    total++;
    if (bus.din_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want 1", bus.din_ready);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.cell_v[i] !== 0 || dut.cell_a[i] !== 0 || dut.cell_ok[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_cell%0d v=%0d a=%0d ok=%b want 0 0 0", i, dut.cell_v[i], dut.cell_a[i], dut.cell_ok[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [W-1:0] d  [5];
    logic [W-1:0] ex [5];
    d  = '{10, 50, 20, 40, 30};
    ex = '{10, 20, 30, 40, 50};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, d[i], 1'b0);
      total++;
      if (bus.dout_valid !== (i == 4) || bus.fill !== (i + 1)) begin
        bad++;
        $display("FAIL fill_step%0d dv=%b fill=%0d want dv=%b fill=%0d", i, bus.dout_valid, bus.fill, i == 4, i + 1);
      end
    end
    total++;
    if (bus.dout !== 30) begin
      bad++;
      $display("FAIL fill_median got=%0d want 30", bus.dout);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.cell_v[i] !== ex[i]) begin
        bad++;
        $display("FAIL fill_cell%0d got=%0d want %0d", i, dut.cell_v[i], ex[i]);
      end
    end
  endtask

  task automatic test_steady();
    logic [W-1:0] d   [4];
    logic [W-1:0] med [4];
    logic [W-1:0] ex  [4][5];
    d   = '{0, 100, 5, 6};
    med = '{30, 30, 30, 6};
    ex  = '{'{0, 20, 30, 40, 50}, '{0, 20, 30, 40, 100}, '{0, 5, 30, 40, 100}, '{0, 5, 6, 30, 100}};
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, d[s], 1'b0);
      total++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== med[s]) begin
        bad++;
        $display("FAIL steady_median%0d dv=%b dout=%0d want 1 %0d", s, bus.dout_valid, bus.dout, med[s]);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (dut.cell_v[i] !== ex[s][i]) begin
          bad++;
          $display("FAIL steady_cell s%0d i%0d got=%0d want %0d", s, i, dut.cell_v[i], ex[s][i]);
        end
      end
    end
  endtask

  task automatic test_ties();
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'd7, 1'b0);
      total++;
      if (bus.dout_valid !== (i >= 4) || (i >= 4 && bus.dout !== 7)) begin
        bad++;
        $display("FAIL ties_seven%0d dv=%b dout=%0d want dv=%b dout=7", i, bus.dout_valid, bus.dout, i >= 4);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd255, 1'b0);
    total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 255) begin
      bad++;
      $display("FAIL ties_max dv=%b dout=%0d want 1 255", bus.dout_valid, bus.dout);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd0, 1'b0);
    total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 0) begin
      bad++;
      $display("FAIL ties_min dv=%b dout=%0d want 1 0", bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] d [5];
    logic [W-1:0] held;
    logic [N:0]   fheld;
    d = '{10, 50, 20, 40, 30};
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, d[i], 1'b0);
      total++;
      if (bus.dout_valid !== (i == 4) || (i == 4 && bus.dout !== 30)) begin
        bad++;
        $display("FAIL gaps_step%0d dv=%b dout=%0d want dv=%b (median 30 at end)", i, bus.dout_valid, bus.dout, i == 4);
      end
      held  = bus.dout;
      fheld = bus.fill;
      cycle(1'b0, 8'd99, 1'b0);
      total++;
      if (bus.dout_valid !== 1'b0 || bus.dout !== held || bus.fill !== fheld) begin
        bad++;
        $display("FAIL gaps_hold%0d dv=%b dout=%0d fill=%0d want 0 %0d %0d", i, bus.dout_valid, bus.dout, bus.fill, held, fheld);
      end
    end
  endtask

  task automatic test_reset_flush();
    cycle(1'b1, 8'd200, 1'b0);
    cycle(1'b1, 8'd201, 1'b0);
    cycle(1'b1, 8'd202, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.fill !== 0 || bus.dout !== 0 || bus.dout_valid !== 1'b0 || dut.cell_ok !== '0) begin
      bad++;
      $display("FAIL midreset fill=%0d dout=%0d dv=%b ok=%b want all zero", bus.fill, bus.dout, bus.dout_valid, dut.cell_ok);
    end
    exp_q.delete();
    win.delete();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) cycle(1'b1, W'(i), 1'b0);
    total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 3) begin
      bad++;
      $display("FAIL refill dv=%b dout=%0d want 1 3", bus.dout_valid, bus.dout);
    end
    bus.flush = 1'b1; bus.din_valid = 1'b1; bus.din = 8'd99;
    #1;
    total++;
    if (bus.din_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b want 0", bus.din_ready);
    end
    cycle(1'b1, 8'd99, 1'b1);
    total++;
    if (bus.fill !== 0 || bus.dout_valid !== 1'b0 || bus.dout !== 0) begin
      bad++;
      $display("FAIL flush_clear fill=%0d dv=%b dout=%0d want 0 0 0", bus.fill, bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_random();
    int           r;
    bit           narrow;
    logic [W-1:0] d;
    for (int n = 0; n < 10000; n++) begin
      if (n % 1000 == 0) narrow = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 199);
      d = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255));
      cycle(r < 160, d, r == 199);
    end
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_ties();
    test_gaps();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_window_sorter.md
Name: median_window_sorter

Overview:
- Streaming running-median engine for the FIFO-based median filter datapath.
- Keeps the last N samples in an ascending sorted cell array. Each cell stores a value and an age.
- On each accepted sample, the oldest entry is evicted and the new sample is inserted at its sorted position, both in one cycle.
- The centre cell is the registered median output. This block is the write side that feeds the per-cell neighbour-select control.

Parameters:
- W, 8, sample width in bits (unsigned).
- N, 5, window length; must be odd and >= 3.
- AW, $clog2(N), width of the age and fill counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of the window contents
- din_valid  in  1  sample strobe
- din  in  W  sample value (unsigned)
- din_ready  out  1  equals ~flush; a sample is accepted when din_valid & din_ready
- dout_valid  out  1  one-cycle pulse: dout holds the median of a full window
- dout  out  W  median, i.e. cell (N-1)/2 after the update
- fill  out  AW+1  number of occupied cells, 0..N

Behaviour:
- **Reset** (rst_n=0, asynchronous): all cell values 0, all ages 0, all cells invalid, fill=0, dout=0, dout_valid=0. A reset mid-stream discards the window immediately.
- **Flush** (synchronous): same clear as reset on the next edge. Flush has priority over a same-cycle sample; that sample is not accepted.
- **Cell state**: v[i], a[i], ok[i] for i = 0..N-1.
  - Valid cells occupy indices 0..fill-1, in ascending v.
  - Invalid cells compare as +infinity.
- **Eviction index k**:
  - fill<N: k = fill (the empty top slot).
  - fill==N: k = the unique i with a[i]==N-1.
- **Insert position**: p = count of valid j != k with v[j] <= din. Ties place the new sample above equal values.
- **Per-cell select** (2-bit code, one per cell):
  - KEEP: default.
  - FROM_RIGHT (v[i+1]): when k<p and k <= i < p.
  - FROM_LEFT (v[i-1]): when p<k and p < i <= k.
  - NEW (din): when i==p.
  - Age moves with the value. Surviving ages are incremented by 1; the new entry gets age 0.
  - ok[i] becomes 1 for i < new fill.
- **Fill counter**: increments on accept while fill<N, then saturates at N.
- **Output timing**:
  - dout is registered; dout = post-update v[(N-1)/2] one cycle after the accepting edge (latency 1).
  - dout_valid=1 in that cycle only if post-update fill==N.
  - Otherwise dout_valid=0 and dout holds its last value.
- **Age invariant**: when fill==N, ages are always a permutation of 0..N-1. Bench asserts this every cycle.
- **Idle cycles** (no accept): the state is unchanged.
- **Ports**: no backpressure on the output side.
- **Timing**: all comparisons (din vs every v[i]) run in parallel in one cycle. There is no multi-cycle sort.

Decomposition:
- Shared package median_pkg:
  - select codes SEL_KEEP=2'b00, SEL_RIGHT=2'b01, SEL_LEFT=2'b10, SEL_NEW=2'b11
  - helper function for the age width
- Sub-module median_sort_cell, instantiated N times:
  - holds v/a/ok
  - takes left/right neighbour values and ages plus din and a select code
  - outputs its comparison bit (din < v) and its oldest flag (a==N-1)
- The top level derives k, p and the per-cell selects from these bits.

Test Plan:
- Fill (N=5, W=8): din 10,50,20,40,30 on consecutive cycles -> dout_valid low for the first 4 results. On the 5th result: dout=30, dout_valid=1, fill=5, cells 10,20,30,40,50.
- Steady state: continue with 0 -> evicts 10 -> cells 0,20,30,40,50, dout=30. Then 100 -> evicts 50 -> cells 0,20,30,40,100, dout=30. Then 5 -> evicts 20 -> dout=30. Then 6 -> evicts 40 -> cells 0,5,6,30,100, dout=6.
- Ties and extremes: ten samples of 7 -> dout=7 from the 5th result on, age permutation intact. Then 255,255,255 -> dout=255 after the third. Then 0 x3 -> dout=0 after the third.
- Gaps: a valid/idle alternating pattern with the same data as the first test -> identical dout sequence. dout and state hold across idle cycles.
- Reset/flush mid-operation: drop rst_n for part of a cycle after 3 samples -> fill=0 and dout=0 immediately. Refill with 1..5 -> dout=3. Flush asserted together with din_valid -> sample dropped, din_ready=0, fill=0 next cycle.
- Randomised: 10k random samples compared against a software sliding-window median, checking dout on every dout_valid. Age-permutation and sorted-order assertions run every cycle.
